ap_ctrl_driver: RTL and testbench
=================================

# ap_ctrl_driver

Synthesizable initiator for the ap_ctrl_hs block-level handshake. Drives ap_start into an HLS top (e.g. mac) for a programmed number of transactions and consumes ap_ready/ap_done. Measures per-transaction latency and max latency in cycles, then emits a one-cycle finish pulse of the kind the dataflow monitors sample. Sits between the testbench/sequencer and the DUT control port.

## Interface
Parameters:
- TXN_W, 16, width of transaction counters and cfg_num_txn
- CNT_W, 32, width of cycle counter, stamps, and latency outputs
- DEPTH, 4, outstanding-transaction stamp FIFO depth (power of 2, ≥2)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high; clears all state
- cfg_start  in  1  run request, sampled only in IDLE
- cfg_num_txn  in  TXN_W  transactions per run, latched on accept
- cfg_gap  in  8  idle cycles inserted after each ap_ready before next ap_start, latched on accept
- ap_start  out  1  handshake start to DUT
- ap_ready  in  1  DUT accepted inputs
- ap_done  in  1  DUT completed one transaction (one-cycle pulse per transaction)
- busy  out  1  high from accept until finish pulse, inclusive
- finish  out  1  one-cycle pulse when run completes
- txn_issued  out  TXN_W  ap_ready handshakes this run
- txn_done  out  TXN_W  matched ap_done pulses this run
- last_latency  out  CNT_W  latency of most recent completed transaction
- max_latency  out  CNT_W  max latency this run
- total_cycles  out  CNT_W  cycle_cnt value latched at finish
- err_unexp_done  out  1  sticky: ap_done seen with stamp FIFO empty

Reset value of every output: 0.

## Operation
- States: IDLE, START, GAP, DRAIN, FIN.
- IDLE: on cfg_start, latch cfg; clear counters, FIFO, errors, latencies; cycle_cnt←0.
  - num=0 → FIN.
  - else → START.
- START: ap_start=1 only if FIFO not full; else ap_start=0 and stay. First cycle ap_start is high for a transaction, push cycle_cnt as stamp.
  - ap_start & ap_ready: txn_issued++.
    - If issued reaches num → DRAIN.
    - elif gap=0 → stay START (back-to-back, new stamp next cycle).
    - else → GAP with gap counter←cfg_gap.
  - ap_start stays high until ap_ready; never deasserted early.
- GAP: ap_start=0; decrement; at 1 → START.
- DRAIN: ap_start=0; wait txn_done == txn_issued → FIN.
- FIN: finish=1 one cycle; total_cycles←cycle_cnt; → IDLE.
- Completion (any state except IDLE): ap_done & FIFO non-empty:
  - pop head;
  - last_latency←cycle_cnt−head (modulo 2^CNT_W);
  - max_latency←max;
  - txn_done++.
- ap_done & FIFO empty: err_unexp_done←1; nothing else changes.
- Push and pop in the same cycle both apply; occupancy unchanged.
- cycle_cnt increments every cycle while busy and saturates at all-ones.
- cfg_start while not IDLE: ignored.
- Counters txn_issued/txn_done wrap is impossible: stop at num.

## Timing
- cfg_start high at edge t (IDLE) → busy and ap_start high from cycle t+1.
- cycle_cnt=0 in that first ap_start cycle.
- Stamp = cycle_cnt in first ap_start-high cycle of that transaction. Transaction latency = cycle index of ap_done − stamp. Example: ap_start first high cycle 0, ap_done cycle 5 → last_latency=5.
- Latency outputs and txn_done update on the edge after the ap_done cycle.
- Back-to-back: ap_ready at cycle k with gap=0 → next stamp = k+1.
- gap=G: ap_ready at k → ap_start low k+1..k+G, high k+G+1.
- Last matched ap_done at cycle d → state FIN at d+1 (finish high cycle d+1), busy low and IDLE from d+2.
- FIFO full: ap_start low combinationally in that START cycle. Pop in the same cycle does not unblock until next cycle.
- Reset mid-run: next cycle all outputs 0, state IDLE, FIFO empty; pending DUT ap_done after reset ignored (IDLE).

## Test plan
- num=1, gap=0; DUT ready at cycle 0, done at 5 → last/max_latency=5, finish at cycle 6, total_cycles=6, txn_done=1.
- num=3, gap=0; ready every cycle, done at 4,5,6 → stamps 0,1,2; latencies 4,4,4; ap_start high cycles 0–2; finish cycle 7.
- num=2, gap=2; ready at 0 → ap_start low 1–2, high 3; dones with latencies 3 and 6 → max_latency=6.
- DEPTH=4, num=6, ready always, first done at cycle 20 → ap_start low from cycle 4 until the cycle after the first pop; txn_issued never exceeds txn_done+4.
- num=0 → finish at t+1 with all counters 0. Stray ap_done during a run with FIFO empty → err_unexp_done=1 sticky, txn_done unchanged.
- Reset at cycle 3 of a 5-txn run → all outputs 0 next cycle. cfg_start while busy has no effect on latched num.

Source files
------------

// File: rtl/ap_ctrl_driver_if.sv
// ap_ctrl_hs block-level handshake bundle between an initiator and an HLS top.
// The master drives ap_start. The slave returns ap_ready and ap_done.
interface ap_ctrl_driver_if;
    logic ap_start;
    logic ap_ready;
    logic ap_done;

    modport master (
        output ap_start,
        input  ap_ready,
        input  ap_done
    );

    modport slave (
        input  ap_start,
        output ap_ready,
        output ap_done
    );
endinterface

// File: rtl/ap_ctrl_driver.sv
// ap_ctrl_hs initiator: issues a programmed number of ap_start transactions and
// measures each transaction's latency with a stamp FIFO. It pulses finish when the run ends.
module ap_ctrl_driver #(
    parameter int unsigned TXN_W = 16,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cfg_start,
    input  logic [TXN_W-1:0]    cfg_num_txn,
    input  logic [7:0]          cfg_gap,
    ap_ctrl_driver_if.master    ap,
    output logic                busy,
    output logic                finish,
    output logic [TXN_W-1:0]    txn_issued,
    output logic [TXN_W-1:0]    txn_done,
    output logic [CNT_W-1:0]    last_latency,
    output logic [CNT_W-1:0]    max_latency,
    output logic [CNT_W-1:0]    total_cycles,
    output logic                err_unexp_done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] FullCnt = PW'(DEPTH);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StStart = 3'd1;
    localparam logic [2:0] StGap   = 3'd2;
    localparam logic [2:0] StDrain = 3'd3;
    localparam logic [2:0] StFin   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [TXN_W-1:0] num_q, num_d;
    logic [7:0]       gap_q, gap_d;
    logic [7:0]       gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic             pushed_q, pushed_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0] mem_d [DEPTH];
    logic [TXN_W-1:0] issued_q, issued_d;
    logic [TXN_W-1:0] done_q, done_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic             err_q, err_d;

    logic [PW-1:0]    fifo_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             ap_start;
    logic             push;
    logic             accept;
    logic             done_evt;
    logic             pop;
    logic [CNT_W-1:0] head;
    logic [CNT_W-1:0] lat;

    always_comb begin
        fifo_cnt   = wr_ptr_q - rd_ptr_q;
        fifo_full  = (fifo_cnt == FullCnt);
        fifo_empty = (fifo_cnt == '0);
        // Once a transaction is stamped, ap_start stays high until ap_ready even if the FIFO fills.
        ap_start   = (state_q == StStart) && (pushed_q || !fifo_full);
        push       = ap_start && !pushed_q;
        accept     = ap_start && ap.ap_ready;
        done_evt   = ap.ap_done && (state_q != StIdle);
        pop        = done_evt && !fifo_empty;
        head       = mem_q[rd_ptr_q[AW-1:0]];
        lat        = cycle_cnt_q - head;
    end

    assign ap.ap_start    = ap_start;
    assign busy           = (state_q != StIdle);
    assign finish         = (state_q == StFin);
    assign txn_issued     = issued_q;
    assign txn_done       = done_q;
    assign last_latency   = last_q;
    assign max_latency    = max_q;
    assign total_cycles   = total_q;
    assign err_unexp_done = err_q;

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        pushed_d    = pushed_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_d       = mem_q;
        issued_d    = issued_q;
        done_d      = done_q;
        last_d      = last_q;
        max_d       = max_q;
        total_d     = total_q;
        err_d       = err_q;

        if (state_q != StIdle && cycle_cnt_q != '1) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end

        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = cycle_cnt_q;
            wr_ptr_d = wr_ptr_q + PW'(1);
            pushed_d = 1'b1;
        end
        if (accept) begin
            pushed_d = 1'b0;
            issued_d = issued_q + TXN_W'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            last_d   = lat;
            max_d    = (lat > max_q) ? lat : max_q;
            done_d   = done_q + TXN_W'(1);
        end else if (done_evt) begin
            err_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (cfg_start) begin
                    num_d       = cfg_num_txn;
                    gap_d       = cfg_gap;
                    gap_cnt_d   = '0;
                    cycle_cnt_d = '0;
                    pushed_d    = 1'b0;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    issued_d    = '0;
                    done_d      = '0;
                    last_d      = '0;
                    max_d       = '0;
                    err_d       = 1'b0;
                    state_d     = (cfg_num_txn == '0) ? StFin : StStart;
                end
            end
            StStart: begin
                if (accept) begin
                    if (issued_d == num_q) begin
                        // A zero-latency DUT may already have completed everything.
                        state_d = (done_d == issued_d) ? StFin : StDrain;
                    end else if (gap_q != '0) begin
                        gap_cnt_d = gap_q;
                        state_d   = StGap;
                    end
                end
            end
            StGap: begin
                if (gap_cnt_q <= 8'd1) begin
                    state_d = StStart;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            StDrain: begin
                if (done_d == issued_q) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                total_d = cycle_cnt_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            num_q       <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            cycle_cnt_q <= '0;
            pushed_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_q       <= '{default: '0};
            issued_q    <= '0;
            done_q      <= '0;
            last_q      <= '0;
            max_q       <= '0;
            total_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            pushed_q    <= pushed_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_q       <= mem_d;
            issued_q    <= issued_d;
            done_q      <= done_d;
            last_q      <= last_d;
            max_q       <= max_d;
            total_q     <= total_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_ap_ctrl_driver.sv
// Directed bench for ap_ctrl_driver. Each run pushes its expected end-of-run record.
// A monitor checks each finish pulse against that record.
module tb_ap_ctrl_driver;

    localparam int TXN_W = 16;
    localparam int CNT_W = 32;
    localparam int DEPTH = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             cfg_start;
    logic [TXN_W-1:0] cfg_num_txn;
    logic [7:0]       cfg_gap;
    logic             busy, finish, err_unexp_done;
    logic [TXN_W-1:0] txn_issued, txn_done;
    logic [CNT_W-1:0] last_latency, max_latency, total_cycles;

    ap_ctrl_driver_if ap ();

    ap_ctrl_driver #(
        .TXN_W(TXN_W),
        .CNT_W(CNT_W),
        .DEPTH(DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .cfg_start      (cfg_start),
        .cfg_num_txn    (cfg_num_txn),
        .cfg_gap        (cfg_gap),
        .ap             (ap),
        .busy           (busy),
        .finish         (finish),
        .txn_issued     (txn_issued),
        .txn_done       (txn_done),
        .last_latency   (last_latency),
        .max_latency    (max_latency),
        .total_cycles   (total_cycles),
        .err_unexp_done (err_unexp_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        longint fin_tick;
        longint total;
        longint issued;
        longint done;
        longint last;
        longint maxl;
        longint err;
    } exp_t;

    exp_t   sb[$];
    int     total = 0;
    int     bad = 0;
    longint tick = 0;
    logic   pend = 1'b0;
    longint pend_total = 0;

    always @(posedge clock) tick <= tick + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // total_cycles is latched on the finish edge, so it is checked one cycle later.
    always @(negedge clock) begin : mon
        exp_t e;
        if (pend) begin
            chk("total_cycles", total_cycles, pend_total);
            chk("busy_after_finish", busy, 0);
            pend = 1'b0;
        end
        if (!reset && finish) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL finish_unexpected: got finish at tick %0d expected none", tick);
            end else begin
                e = sb.pop_front();
                chk("finish_tick", tick, e.fin_tick);
                chk("busy_at_finish", busy, 1);
                chk("txn_issued", txn_issued, e.issued);
                chk("txn_done", txn_done, e.done);
                chk("last_latency", last_latency, e.last);
                chk("max_latency", max_latency, e.maxl);
                chk("err_unexp_done", err_unexp_done, e.err);
                pend       = 1'b1;
                pend_total = e.total;
            end
        end
    end

    function automatic logic [63:0] b(input int lo, input int hi);
        logic [63:0] v = '0;
        for (int i = lo; i <= hi; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Leaves the bench just after the edge that accepts the run, i.e. in cycle 0.
    task automatic start_run(input int num, input int gap, input int fin, input int iss,
                             input int dn, input int last, input int mx, input int err,
                             input bit push_sb);
        exp_t e;
        cfg_num_txn = TXN_W'(num);
        cfg_gap     = 8'(gap);
        cfg_start   = 1'b1;
        @(posedge clock);
        #1;
        cfg_start = 1'b0;
        if (push_sb) begin
            e.fin_tick = tick + fin;
            e.total    = fin;
            e.issued   = iss;
            e.done     = dn;
            e.last     = last;
            e.maxl     = mx;
            e.err      = err;
            sb.push_back(e);
        end
    endtask

    task automatic run_vec(input string tag, input int ncyc, input logic [63:0] rdy,
                           input logic [63:0] dn, input logic [63:0] st,
                           input logic [63:0] cs);
        for (int c = 0; c < ncyc; c++) begin
            ap.ap_ready = rdy[c];
            ap.ap_done  = dn[c];
            cfg_start   = cs[c];
            @(negedge clock);
            chk($sformatf("%s ap_start c%0d", tag, c), ap.ap_start, st[c]);
            chk($sformatf("%s occ_bound c%0d", tag, c),
                (32'(txn_issued) <= 32'(txn_done) + DEPTH) ? 1 : 0, 1);
            @(posedge clock);
            #1;
        end
        ap.ap_ready = 1'b0;
        ap.ap_done  = 1'b0;
        cfg_start   = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " finish"}, finish, 0);
        chk({tag, " ap_start"}, ap.ap_start, 0);
        chk({tag, " txn_issued"}, txn_issued, 0);
        chk({tag, " txn_done"}, txn_done, 0);
        chk({tag, " last_latency"}, last_latency, 0);
        chk({tag, " max_latency"}, max_latency, 0);
        chk({tag, " total_cycles"}, total_cycles, 0);
        chk({tag, " err"}, err_unexp_done, 0);
    endtask

    initial begin
        reset       = 1'b1;
        cfg_start   = 1'b0;
        cfg_num_txn = '0;
        cfg_gap     = '0;
        ap.ap_ready = 1'b0;
        ap.ap_done  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk_zero("reset");
        @(posedge clock);
        #1;

        // Single transaction: stamp 0, done at 5.
        start_run(1, 0, 6, 1, 1, 5, 5, 0, 1);
        run_vec("one", 8, b(0, 0), b(5, 5), b(0, 0), '0);

        // Back-to-back stamps 0,1,2; dones 4,5,6.
        start_run(3, 0, 7, 3, 3, 4, 4, 0, 1);
        run_vec("b2b", 9, b(0, 2), b(4, 6), b(0, 2), '0);

        // Gap of 2: second start at 3; latencies 3 then 6.
        start_run(2, 2, 10, 2, 2, 6, 6, 0, 1);
        run_vec("gap", 12, b(0, 0) | b(3, 3), b(3, 3) | b(9, 9), b(0, 0) | b(3, 3), '0);

        // FIFO full from cycle 4; first pop at 20 frees a slot in cycle 21.
        start_run(6, 0, 32, 6, 6, 9, 20, 0, 1);
        run_vec("full", 34, b(0, 40), b(20, 23) | b(30, 31), b(0, 3) | b(21, 22), '0);

        // Zero transactions finish immediately.
        start_run(0, 0, 0, 0, 0, 0, 0, 0, 1);
        run_vec("zero", 2, '0, '0, '0, '0);

        // Stray done at cycle 3 while the FIFO is empty during the gap.
        start_run(2, 5, 9, 2, 2, 2, 2, 1, 1);
        run_vec("stray", 11, b(0, 0) | b(6, 6), b(1, 1) | b(3, 3) | b(8, 8),
                b(0, 0) | b(6, 6), '0);
        @(negedge clock);
        chk("err_sticky", err_unexp_done, 1);
        @(posedge clock);
        #1;

        // A second cfg_start while busy must not change the latched count.
        start_run(2, 0, 4, 2, 2, 2, 2, 0, 1);
        cfg_num_txn = TXN_W'(7);
        run_vec("busy_cfg", 6, b(0, 1), b(2, 3), b(0, 1), b(1, 1));

        // Reset in cycle 3 of a 5-transaction run.
        start_run(5, 0, 0, 0, 0, 0, 0, 0, 0);
        run_vec("rst_run", 3, b(0, 5), '0, b(0, 2), '0);
        reset       = 1'b1;
        ap.ap_ready = 1'b1;
        @(negedge clock);
        chk("rst_run ap_start c3", ap.ap_start, 1);
        chk("rst_run issued c3", txn_issued, 3);
        @(posedge clock);
        #1;
        reset       = 1'b0;
        ap.ap_ready = 1'b0;
        ap.ap_done  = 1'b1;
        @(negedge clock);
        chk_zero("after_reset");
        @(posedge clock);
        #1;
        ap.ap_done = 1'b0;
        @(negedge clock);
        chk_zero("late_done");
        @(posedge clock);
        #1;

        repeat (2) @(posedge clock);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
